mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store). It sequences each access over a fixed multi-cycle memory latency. It returns read data and a one-cycle ready pulse to the owner, and produces per-stage stall signals. Those stall signals are OR-ed with the hazard unit's stall into PC/IFID write enables. A flush input discards an in-flight fetch whose result is no longer wanted.

## Interface
- LAT, 2: memory latency in cycles from command to valid ram_rdata; legal range 1..15.
- MAX_STREAK, 3: consecutive contested MEM grants allowed before IF is forced a grant; legal range 1..7.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF requests a fetch; held until if_ready or if_flush.
- if_addr  in  32  fetch address.
- if_flush  in  1  discard any pending/in-flight fetch, e.g. jump or branch taken.
- if_rdata  out  32  fetched word, registered.
- if_ready  out  1  one-cycle pulse; if_rdata valid.
- if_stall  out  1  IF must hold PC/IFID.
- mem_req  in  1  MEM requests a load/store; held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, registered.
- mem_ready  out  1  one-cycle completion pulse.
- mem_stall  out  1  MEM, and everything upstream, must hold.
- ram_en  out  1  memory command strobe, one cycle per access.
- ram_we  out  1  write enable, qualified by ram_en.
- ram_addr  out  32  registered command address.
- ram_wdata  out  32  registered write data.
- ram_rdata  in  32  memory read data.

## Operation
- State machine with three states: IDLE, BUSY, DONE. Register owner: 0 = IF, 1 = MEM. Also registers cnt (4 bits), streak (3 bits) and discard (1 bit).
- IDLE: grant decision is combinational on requests; state transfers at the edge.
  - Only mem_req asserted: grant MEM and clear streak.
  - Only if_req asserted, with if_flush low: grant IF and clear streak.
  - Both asserted: grant MEM when streak < MAX_STREAK, then streak += 1. Otherwise grant IF and clear streak.
  - if_req with if_flush high is treated as no IF request.
- On a grant: state goes to BUSY and cnt = LAT.
  - ram_en = 1 in the first BUSY cycle only.
  - ram_we = mem_we for a MEM grant, 0 for an IF grant.
  - ram_addr and ram_wdata are latched at the grant edge.
  - discard is cleared.
- BUSY: cnt decrements each edge. When cnt == 1, the arbiter captures ram_rdata into the owner's rdata register, except on a MEM write, where mem_rdata is unchanged. It then moves to DONE.
- DONE: lasts one cycle, then state returns to IDLE. Requests are ignored in DONE.
  - if_ready = owner==IF & ~discard & ~if_flush.
  - mem_ready = owner==MEM.
- Flush: if_flush high in any BUSY or DONE cycle with owner==IF sets discard. The memory access still completes; it cannot be aborted.
  - if_rdata is still updated.
  - if_ready is suppressed.
- Stalls are combinational:
  - if_stall = if_req & ~if_ready & ~if_flush.
  - mem_stall = mem_req & ~mem_ready.
- Access occupancy is LAT+1 cycles, plus one IDLE cycle before the next grant. Back-to-back throughput is one access per LAT+2 cycles.

## Timing
- Reset (reset=0) forces outputs and state, asynchronously:
  - State IDLE; owner, cnt, streak and discard 0.
  - ram_en, ram_we, if_ready and mem_ready 0; ram_addr, ram_wdata, if_rdata and mem_rdata 0.
  - Stalls then follow their equations.
- Reset asserted mid-access abandons the access: no ready pulse and no further ram_en. First grant is possible in the first cycle after reset deasserts.
- Latency, request seen in IDLE cycle T:
  - ram_en in cycle T+1.
  - ram_rdata sampled at the end of cycle T+LAT.
  - ready in cycle T+LAT+1.
  - IDLE again in T+LAT+2.
- With LAT=1, BUSY lasts exactly one cycle: ram_en cycle and capture cycle are the same.
- A request dropped before its grant is never granted. A request dropped during BUSY does not cancel the access. Requesters must hold address and data stable until ready.
- streak saturates at MAX_STREAK and is never wrapped.

## Test plan
- LAT=2, reset release, then if_req with if_addr=0x00400000 and ram_rdata=0x8C080004:
  - Requested in cycle 0 (IDLE): ram_en=1 in cycle 1.
  - if_ready=1 and if_rdata=0x8C080004 in cycle 3; if_stall high in cycles 0–2.
- mem_req with mem_we=1, addr 0x10, data 0xDEADBEEF:
  - ram_en=ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF for one cycle.
  - mem_ready after LAT+1 cycles; mem_rdata unchanged.
- if_req and mem_req both held continuously, MAX_STREAK=3: grant order is MEM, MEM, MEM, IF, MEM, MEM, MEM, IF…
- IF access in BUSY, if_flush pulsed one cycle: access completes, if_ready never pulses, the next IDLE grants the pending mem_req.
- reset pulled low during BUSY of a MEM load: all outputs zero immediately, and no mem_ready follows after release until a new grant.
- LAT=1: if_req in cycle 0 gives ram_en in cycle 1 and if_ready in cycle 2.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM requesters, the shared memory and the port arbiter.
// No latency of its own; plain wires.
// Backpressure is carried by the stall/ready signals driven on the slave side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata,
        output if_rdata, if_ready, if_stall,
        output mem_rdata, mem_ready, mem_stall,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requesters and memory side.
    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata,
        input  if_rdata, if_ready, if_stall,
        input  mem_rdata, mem_ready, mem_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (IF) and load/store (MEM).
// Latency: request in IDLE cycle T -> ram_en T+1, ready pulse T+LAT+1, IDLE again T+LAT+2.
// Backpressure: the losing or waiting requester sees its stall held until its ready pulse.
module mem_port_arbiter #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned MAX_STREAK = 3
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ram_cmd_t;

    localparam logic [3:0] LAT_CNT    = 4'(LAT);
    localparam logic [2:0] STREAK_MAX = 3'(MAX_STREAK);
    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_MEM    = 1'b1;

    state_t      state;
    logic        owner;
    logic [3:0]  cnt;
    logic [2:0]  streak;
    logic        discard;
    logic        op_we;
    logic        ram_en_q;
    logic        ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        if_ready_q;
    logic        mem_ready_q;

    logic        if_want;
    logic        contested;
    logic        grant_mem;
    logic        grant_if;
    logic [2:0]  streak_nxt;
    ram_cmd_t    cmd_nxt;

    // A flushed fetch request is not a request at all for arbitration.
    always_comb begin
        if_want   = bus.if_req & ~bus.if_flush;
        contested = if_want & bus.mem_req;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state == IDLE) begin
            grant_mem = bus.mem_req & (~if_want | (streak < STREAK_MAX));
            grant_if  = if_want & ~grant_mem;
        end
        // Only reached while streak < STREAK_MAX, so the increment saturates there.
        streak_nxt = (grant_mem & contested) ? streak + 3'd1 : 3'd0;
        if (grant_mem) begin
            cmd_nxt = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
        end else begin
            cmd_nxt = '{we: 1'b0, addr: bus.if_addr, wdata: 32'd0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            cnt         <= 4'd0;
            streak      <= 3'd0;
            discard     <= 1'b0;
            op_we       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem | grant_if) begin
                        state       <= BUSY;
                        owner       <= grant_mem ? OWN_MEM : OWN_IF;
                        cnt         <= LAT_CNT;
                        streak      <= streak_nxt;
                        discard     <= 1'b0;
                        op_we       <= cmd_nxt.we;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= cmd_nxt.we;
                        ram_addr_q  <= cmd_nxt.addr;
                        ram_wdata_q <= cmd_nxt.wdata;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (owner == OWN_IF && bus.if_flush) begin
                        discard <= 1'b1;
                    end
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        if (owner == OWN_IF) begin
                            // The word is kept even when the fetch was flushed.
                            if_rdata_q <= bus.ram_rdata;
                            if_ready_q <= ~(discard | bus.if_flush);
                        end else begin
                            if (!op_we) begin
                                mem_rdata_q <= bus.ram_rdata;
                            end
                            mem_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (owner == OWN_IF && bus.if_flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flush arriving in the DONE cycle still kills the fetch ready pulse.
    assign bus.if_ready  = if_ready_q & ~bus.if_flush;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_ready & ~bus.if_flush;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_stall = bus.mem_req & ~mem_ready_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LAT=2/MAX_STREAK=3 instance with a scoreboard, plus a LAT=1 instance.
// Memory model returns valid data only in the capture cycle, garbage otherwise.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] if_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] grant_q[$];

    mem_port_arbiter_if ifc();
    mem_port_arbiter_if ifc1();

    mem_port_arbiter #(.LAT(LAT0), .MAX_STREAK(3)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    mem_port_arbiter #(.LAT(1), .MAX_STREAK(3)) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: data is only presented in the cycle the arbiter samples it.
    logic [31:0] ram_mem [0:255];
    int          age = 31;
    logic        rd_valid;

    always @(posedge clk) begin
        if (!reset) begin
            ram_mem[0] <= 32'h8C08_0004;
            ram_mem[1] <= 32'h1111_1111;
            ram_mem[2] <= 32'h3333_3333;
            ram_mem[8] <= 32'h2222_2222;
        end else if (ifc.ram_en && ifc.ram_we) begin
            ram_mem[ifc.ram_addr[9:2]] <= ifc.ram_wdata;
        end
    end

    always @(posedge clk) begin
        if (ifc.ram_en) age <= 1;
        else if (age < 31) age <= age + 1;
    end

    assign rd_valid       = !ifc.ram_en && (age == LAT0 - 1);
    assign ifc.ram_rdata  = rd_valid ? ram_mem[ifc.ram_addr[9:2]] : 32'hBAD0_BAD0;
    assign ifc1.ram_rdata = ifc1.ram_en ? (32'hCAFE_F00D ^ ifc1.ram_addr) : 32'hBAD0_BAD0;

    // Scoreboard monitor for the LAT=2 instance.
    always @(negedge clk) begin
        if (reset) begin
            if (ifc.if_ready) begin
                if (if_q.size() == 0) check_eq("if_ready_unexpected", {31'd0, ifc.if_ready}, 32'd0);
                else check_eq("if_rdata", ifc.if_rdata, if_q.pop_front());
            end
            if (ifc.mem_ready) begin
                if (mem_q.size() == 0) check_eq("mem_ready_unexpected", {31'd0, ifc.mem_ready}, 32'd0);
                else check_eq("mem_rdata", ifc.mem_rdata, mem_q.pop_front());
            end
            if (ifc.ram_en && grant_q.size() > 0) begin
                check_eq("grant_addr", ifc.ram_addr, grant_q.pop_front());
            end
        end
    end

    task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit seen;
        seen = 1'b0;
        ifc.mem_req   = 1'b1;
        ifc.mem_we    = we;
        ifc.mem_addr  = a;
        ifc.mem_wdata = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifc.mem_ready) seen = 1'b1;
        end
        check_eq("mem_access_done", {31'd0, seen}, 32'd1);
        tick();
        ifc.mem_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        ifc.if_req = 1'b0;  ifc.if_addr = 32'd0;  ifc.if_flush = 1'b0;
        ifc.mem_req = 1'b0; ifc.mem_we = 1'b0;    ifc.mem_addr = 32'd0; ifc.mem_wdata = 32'd0;
        ifc1.if_req = 1'b0; ifc1.if_addr = 32'd0; ifc1.if_flush = 1'b0;
        ifc1.mem_req = 1'b0; ifc1.mem_we = 1'b0;  ifc1.mem_addr = 32'd0; ifc1.mem_wdata = 32'd0;

        // Reset state; stalls follow their equations.
        repeat (2) @(posedge clk);
        ifc.if_req  = 1'b1;
        ifc.mem_req = 1'b1;
        @(negedge clk);
        check_eq("rst_ram_en",    {31'd0, ifc.ram_en}, 32'd0);
        check_eq("rst_ram_addr",  ifc.ram_addr, 32'd0);
        check_eq("rst_if_ready",  {31'd0, ifc.if_ready}, 32'd0);
        check_eq("rst_mem_ready", {31'd0, ifc.mem_ready}, 32'd0);
        check_eq("rst_if_stall",  {31'd0, ifc.if_stall}, 32'd1);
        check_eq("rst_mem_stall", {31'd0, ifc.mem_stall}, 32'd1);
        ifc.if_req  = 1'b0;
        ifc.mem_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();

        // Single fetch, LAT=2.
        ifc.if_req  = 1'b1;
        ifc.if_addr = 32'h0040_0000;
        if_q.push_back(32'h8C08_0004);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t1_ram_en_c%0d", c),   {31'd0, ifc.ram_en},   {31'd0, c == 1});
            check_eq($sformatf("t1_if_stall_c%0d", c), {31'd0, ifc.if_stall}, {31'd0, c < 3});
            check_eq($sformatf("t1_if_ready_c%0d", c), {31'd0, ifc.if_ready}, {31'd0, c == 3});
            if (c == 1) check_eq("t1_ram_addr", ifc.ram_addr, 32'h0040_0000);
            tick();
        end
        ifc.if_req = 1'b0;
        tick();

        // Store: one-cycle write command, mem_rdata untouched.
        ifc.mem_req   = 1'b1;
        ifc.mem_we    = 1'b1;
        ifc.mem_addr  = 32'h10;
        ifc.mem_wdata = 32'hDEAD_BEEF;
        mem_q.push_back(32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t2_ram_en_c%0d", c),    {31'd0, ifc.ram_en},    {31'd0, c == 1});
            check_eq($sformatf("t2_ram_we_c%0d", c),    {31'd0, ifc.ram_we},    {31'd0, c == 1});
            check_eq($sformatf("t2_mem_ready_c%0d", c), {31'd0, ifc.mem_ready}, {31'd0, c == 3});
            check_eq($sformatf("t2_mem_stall_c%0d", c), {31'd0, ifc.mem_stall}, {31'd0, c < 3});
            if (c == 1) begin
                check_eq("t2_ram_addr",  ifc.ram_addr,  32'h10);
                check_eq("t2_ram_wdata", ifc.ram_wdata, 32'hDEAD_BEEF);
            end
            tick();
        end
        ifc.mem_req = 1'b0;
        tick();

        // Load back what was stored.
        mem_q.push_back(32'hDEAD_BEEF);
        mem_access(1'b0, 32'h10, 32'd0);
        tick();

        // Contested: MEM, MEM, MEM, IF, repeated.
        ifc.if_addr  = 32'h0040_0004;
        ifc.mem_addr = 32'h20;
        ifc.mem_we   = 1'b0;
        for (int g = 0; g < 8; g++) begin
            if (g % 4 == 3) begin
                grant_q.push_back(32'h0040_0004);
                if_q.push_back(32'h1111_1111);
            end else begin
                grant_q.push_back(32'h20);
                mem_q.push_back(32'h2222_2222);
            end
        end
        ifc.if_req  = 1'b1;
        ifc.mem_req = 1'b1;
        for (int c = 0; c < 8 * (LAT0 + 2); c++) tick();
        ifc.if_req  = 1'b0;
        ifc.mem_req = 1'b0;
        check_eq("t3_grants_left", grant_q.size(), 32'd0);
        check_eq("t3_if_left",     if_q.size(),    32'd0);
        check_eq("t3_mem_left",    mem_q.size(),   32'd0);
        tick();

        // Flush during an IF access; the pending MEM load is granted next.
        ifc.if_req  = 1'b1;
        ifc.if_addr = 32'h0040_0008;
        @(negedge clk);
        check_eq("t4_if_stall_c0", {31'd0, ifc.if_stall}, 32'd1);
        tick();
        ifc.if_flush = 1'b1;
        ifc.if_req   = 1'b0;
        ifc.mem_req  = 1'b1;
        ifc.mem_we   = 1'b0;
        ifc.mem_addr = 32'h20;
        mem_q.push_back(32'h2222_2222);
        @(negedge clk);
        check_eq("t4_ram_en_c1",    {31'd0, ifc.ram_en},    32'd1);
        check_eq("t4_mem_stall_c1", {31'd0, ifc.mem_stall}, 32'd1);
        tick();
        ifc.if_flush = 1'b0;
        grant_q.push_back(32'h20);
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("t4_if_ready_c%0d", c),  {31'd0, ifc.if_ready},  32'd0);
            check_eq($sformatf("t4_mem_ready_c%0d", c), {31'd0, ifc.mem_ready}, {31'd0, c == 7});
            check_eq($sformatf("t4_ram_en_c%0d", c),    {31'd0, ifc.ram_en},    {31'd0, c == 5});
            tick();
        end
        ifc.mem_req = 1'b0;
        check_eq("t4_if_rdata_kept", ifc.if_rdata, 32'h3333_3333);
        check_eq("t4_mem_left",      mem_q.size(), 32'd0);
        tick();

        // Reset in the middle of a MEM load.
        ifc.mem_req  = 1'b1;
        ifc.mem_we   = 1'b0;
        ifc.mem_addr = 32'h20;
        tick();
        @(negedge clk);
        check_eq("t5_ram_en_before", {31'd0, ifc.ram_en}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("t5_ram_en",    {31'd0, ifc.ram_en},    32'd0);
        check_eq("t5_ram_addr",  ifc.ram_addr,           32'd0);
        check_eq("t5_if_rdata",  ifc.if_rdata,           32'd0);
        check_eq("t5_mem_rdata", ifc.mem_rdata,          32'd0);
        check_eq("t5_mem_stall", {31'd0, ifc.mem_stall}, 32'd1);
        ifc.mem_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("t5_no_ready_c%0d", c), {31'd0, ifc.mem_ready}, 32'd0);
            check_eq($sformatf("t5_no_ram_en_c%0d", c), {31'd0, ifc.ram_en},  32'd0);
            tick();
        end

        // LAT=1 instance: ram_en in cycle 1, ready in cycle 2.
        ifc1.if_req  = 1'b1;
        ifc1.if_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6_ram_en_c%0d", c),   {31'd0, ifc1.ram_en},   {31'd0, c == 1});
            check_eq($sformatf("t6_if_ready_c%0d", c), {31'd0, ifc1.if_ready}, {31'd0, c == 2});
            if (c == 2) check_eq("t6_if_rdata", ifc1.if_rdata, 32'hCAFE_F00D ^ 32'h100);
            tick();
        end
        ifc1.if_req = 1'b0;
        repeat (3) tick();

        check_eq("end_if_q",    if_q.size(),    32'd0);
        check_eq("end_mem_q",   mem_q.size(),   32'd0);
        check_eq("end_grant_q", grant_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
